// File: rtl/reg_file_pkg.sv
// Shared constants for the destination-register select path.
// Used by the select, the ALU datapath and the register file.
package reg_file_pkg;

    localparam int REG_WIDTH_DEF  = 3;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ZERO_REG_ADDR  = 0;

    // Number of entries addressed by an address of the given width.
    function automatic int reg_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/reg_file_wr_decoder.sv
// One-hot write decoder: demux counterpart of the destination select.
// Row 0 is masked when it is hardwired to zero.
module reg_wr_decoder
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_DEF,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                      wr_en,
    input  logic [REG_WIDTH-1:0]      wr_addr,
    output logic [2**REG_WIDTH-1:0]   row_en
);

    // Raise exactly one row enable for a write, except a dropped row 0.
    always_comb begin
        row_en = '0;
        if (wr_en) begin
            row_en[wr_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            row_en[ZERO_REG_ADDR] = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Write-back register file: one-hot write decode, array of flops,
// two combinational read ports with optional same-cycle bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_WIDTH-1:0]  rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [REG_WIDTH-1:0]  rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  wr_ack
);

    localparam int DEPTH = 2**REG_WIDTH;

    logic [DEPTH-1:0]      row_en;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_ack_q;
    logic                  wr_ack_d;

    // A write held during reset never reaches the decoder, so it
    // can neither commit, bypass, nor raise wr_ack.
    assign wr_req = wr_en & ~rst;

    reg_wr_decoder #(
        .REG_WIDTH (REG_WIDTH),
        .ZERO_REG  (ZERO_REG)
    ) u_wr_dec (
        .wr_en   (wr_req),
        .wr_addr (wr_addr),
        .row_en  (row_en)
    );

    // Next array contents: the enabled row takes the write-back data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = row_en[i] ? wr_data : mem_q[i];
        end
        wr_ack_d = |row_en;
    end

    // Array and ack flops; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ack_q <= wr_ack_d;
        end
    end

    // Read port 1: reset forces 0, then bypass, then zero row, then array.
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        if (rst) begin
            rd_data1 = '0;
        end else if (BYPASS && row_en[rd_addr1]) begin
            rd_data1 = wr_data;
        end else if (ZERO_REG && (int'(rd_addr1) == ZERO_REG_ADDR)) begin
            rd_data1 = '0;
        end
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        rd_data2 = mem_q[rd_addr2];
        if (rst) begin
            rd_data2 = '0;
        end else if (BYPASS && row_en[rd_addr2]) begin
            rd_data2 = wr_data;
        end else if (ZERO_REG && (int'(rd_addr2) == ZERO_REG_ADDR)) begin
            rd_data2 = '0;
        end
    end

    assign wr_ack = wr_ack_q;

endmodule
